// File: rtl/stream_1d_to_3d_sub_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stream_1d_to_3d_sub_array                                    |
// | Description : Collects a flat element stream (ELEMS_PER_BEAT elements per  |
// |               valid/ready beat) into a ROWS x COLS frame in sub-array      |
// |               order (top SUB_ROWS rows column-major, then the remaining    |
// |               rows column-major) and publishes each completed frame with   |
// |               its own valid/ready handshake.                               |
// |               Optional macro STREAM_CONVERT_DOUBLE_BUFFER_EN selects a     |
// |               two-bank ping-pong frame store for gapless streaming.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module stream_1d_to_3d_sub_array #(
  parameter int BIT_WIDTH      = 4,
  parameter int ROWS           = 8,
  parameter int COLS           = 8,
  parameter int SUB_ROWS       = 4,
  parameter int ELEMS_PER_BEAT = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [ELEMS_PER_BEAT*BIT_WIDTH-1:0]       in_data,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic                                      in_last,
  output logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0]  out,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic                                      frame_err
);

  localparam int C_NB  = ROWS * COLS / ELEMS_PER_BEAT;
  localparam int C_RIW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int C_CW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int C_BW  = (C_NB > 1) ? $clog2(C_NB) : 1;

  logic [C_RIW-1:0] r_row;
  logic [C_RIW:0]   w_row_sum;
  logic [C_CW-1:0]  r_col;
  logic             r_region_b;
  logic [C_BW-1:0]  r_beat;
  logic             r_armed;
  logic             r_frame_err;
  logic             w_acc;
  logic             w_final;
  logic             w_wrap;

  assign w_acc     = in_valid && in_ready;
  assign w_final   = (r_beat == C_BW'(C_NB - 1));
  assign w_row_sum = {1'b0, r_row} + (C_RIW+1)'(ELEMS_PER_BEAT);
  // The row base wraps at the bottom of whichever region is being filled.
  assign w_wrap    = r_region_b ? (w_row_sum == (C_RIW+1)'(ROWS))
                                : (w_row_sum == (C_RIW+1)'(SUB_ROWS));
  assign frame_err = r_frame_err;

  // Placement counters: beat index, row base, column and region flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat     <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_region_b <= 1'b0;
    end else if (w_acc) begin
      if (w_final || in_last) begin
        // Frame finished or aborted by an early in_last: restart at beat 0.
        r_beat     <= '0;
        r_row      <= '0;
        r_col      <= '0;
        r_region_b <= 1'b0;
      end else begin
        r_beat <= r_beat + 1'b1;
        if (w_wrap) begin
          if (!r_region_b && (r_col == C_CW'(COLS - 1))) begin
            r_col      <= '0;
            r_row      <= C_RIW'(SUB_ROWS);
            r_region_b <= 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
            r_row <= r_region_b ? C_RIW'(SUB_ROWS) : '0;
          end
        end else begin
          r_row <= w_row_sum[C_RIW-1:0];
        end
      end
    end
  end

  // One-cycle error pulse whenever in_last disagrees with the final-beat position.
  always_ff @(posedge clk) begin
    if (rst) r_frame_err <= 1'b0;
    else     r_frame_err <= w_acc && (in_last != w_final);
  end

  // Holds in_ready low through reset and releases it one cycle after.
  always_ff @(posedge clk) begin
    if (rst) r_armed <= 1'b0;
    else     r_armed <= 1'b1;
  end

`ifdef STREAM_CONVERT_DOUBLE_BUFFER_EN

  logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0] r_bank [2];
  logic [1:0] r_full;
  logic       r_wr;
  logic       r_rd;
  logic       w_take;
  logic       w_done;

  assign w_take = out_valid && out_ready;
  assign w_done = w_acc && w_final;
  assign out    = r_bank[r_rd];

  // Input stalls only when both banks hold unconsumed frames.
  always_comb begin
    in_ready  = r_armed && !(&r_full);
    out_valid = r_full[r_rd];
  end

  // Bank ownership: completion hands the fill bank over, a handshake frees the publish bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 2'b00;
      r_wr   <= 1'b0;
      r_rd   <= 1'b0;
    end else begin
      if (w_take) begin
        r_full[r_rd] <= 1'b0;
        r_rd         <= ~r_rd;
      end
      if (w_done) begin
        r_full[r_wr] <= 1'b1;
        r_wr         <= ~r_wr;
      end
    end
  end

  // Scatter each accepted beat down one column of the fill bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank[0] <= '0;
      r_bank[1] <= '0;
    end else if (w_acc) begin
      for (int e = 0; e < ELEMS_PER_BEAT; e++) begin
        r_bank[r_wr][r_row + C_RIW'(e)][r_col] <= in_data[e*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

`else

  localparam logic [0:0] C_S_FILL = 1'b0;
  localparam logic [0:0] C_S_FULL = 1'b1;

  logic [0:0] r_state;
  logic [0:0] w_state_nxt;
  logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0] r_buf;

  assign out = r_buf;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= C_S_FILL;
    else     r_state <= w_state_nxt;
  end

  // Next state: FILL until the final beat lands, FULL until the frame is taken.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_S_FILL: if (w_acc && w_final) w_state_nxt = C_S_FULL;
      C_S_FULL: if (out_ready)        w_state_nxt = C_S_FILL;
      default:                        w_state_nxt = C_S_FILL;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    in_ready  = r_armed && (r_state == C_S_FILL);
    out_valid = (r_state == C_S_FULL);
  end

  // Scatter each accepted beat down one column; writes only occur while filling.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf <= '0;
    end else if (w_acc) begin
      for (int e = 0; e < ELEMS_PER_BEAT; e++) begin
        r_buf[r_row + C_RIW'(e)][r_col] <= in_data[e*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

`endif

endmodule
`default_nettype wire

// File: doc/stream_1d_to_3d_sub_array.md
Name: stream_1d_to_3d_sub_array

Overview:
Streaming successor to the combinational 1D-to-3D sub-array converter. It accepts a flat element stream in beats of ELEMS_PER_BEAT elements over a valid/ready handshake and scatters each beat into a ROWS x COLS buffer using sub-array ordering. The ordering is the top SUB_ROWS rows column-major first, then the remaining rows column-major. Each completed frame is published as a full 3D array with its own valid/ready handshake, so producers with narrow buses can feed array consumers such as a PE grid.

Parameters:
- BIT_WIDTH, 4: element width.
- ROWS, 8: array rows.
- COLS, 8: array columns.
- SUB_ROWS, 4: rows in the first sub-array region; 1 <= SUB_ROWS <= ROWS.
- ELEMS_PER_BEAT, 4: elements per input beat.
  - Must divide SUB_ROWS.
  - Must divide ROWS-SUB_ROWS, when that is nonzero.
  - Consequence: a beat never spans two columns.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous active-high reset.
- in_data, input, ELEMS_PER_BEAT*BIT_WIDTH: beat; element e sits at bits [e*BIT_WIDTH +: BIT_WIDTH].
- in_valid, input, 1: beat valid.
- in_ready, output, 1: beat accepted when in_valid && in_ready.
- in_last, input, 1: marks the final beat of a frame.
- out, output, [BIT_WIDTH-1:0] x [ROWS-1:0][COLS-1:0]: published array.
- out_valid, output, 1: out holds a complete frame.
- out_ready, input, 1: consumer takes the frame when out_valid && out_ready.
- frame_err, output, 1: one-cycle pulse on an in_last mismatch.

Behaviour:
- Clocking and reset:
  - Single clock. Reset is synchronous and active-high: clk and rst.
  - While rst is high: out_valid=0, in_ready=0, frame_err=0, all out elements=0, counters cleared, state FILL.
  - in_ready rises the cycle after rst falls.
  - A rst assertion mid-frame discards the partial frame and any published frame.
- Beat placement:
  - Beat counter b runs 0..NB-1, where NB = ROWS*COLS/ELEMS_PER_BEAT.
  - Placement is tracked by counters (col j, row base r, region flag), not by division.
  - Region A: element e of the beat goes to out[r+e][j]. r advances by ELEMS_PER_BEAT; at SUB_ROWS it wraps to 0 and j increments.
  - After column COLS-1 of region A, the block switches to region B with r=SUB_ROWS, j=0.
  - Region B: r wraps at ROWS back to SUB_ROWS.
  - If SUB_ROWS==ROWS, region B is skipped.
- State machine (without double buffering):
  - FILL: in_ready=1. Accepting beat NB-1 moves to FULL; out_valid=1 from the next cycle.
  - FULL: in_ready=0, out stable. out_valid && out_ready moves to FILL with counters at 0; in_ready=1 the next cycle.
- Latency: the last beat is accepted at cycle t; out_valid=1 and the frame is visible at t+1.
- in_last checking:
  - in_last=1 on beat b<NB-1: the partial frame is discarded, counters reset to 0, nothing is published, frame_err pulses at the next cycle.
  - in_last=0 on beat NB-1: the frame is still published normally, frame_err pulses.
- Holding rules:
  - out_valid, once high, holds until the handshake completes.
  - out does not change while out_valid=1.
  - in_data is ignored when in_valid=0.

Optional Feature:
- Macro STREAM_CONVERT_DOUBLE_BUFFER_EN.
- Defined:
  - Two banks. Fill bank and publish bank swap on frame completion.
  - in_ready=0 only while both banks are full.
  - On the same cycle as a final-beat accept and an out handshake, the new bank publishes with no gap: out_valid stays 1.
  - Sustains one beat per cycle continuously.
- Undefined: single bank, with the FILL/FULL behaviour above. There is a gap of at least one cycle between frames.

Test Plan:
1. Defaults; stream 16 beats, element k = k mod 16, in_last on beat 15, out_ready=0.
   - out[0..3][0]=0,1,2,3; out[0..3][1]=4..7; out[4..7][0]=0,1,2,3 (k=32..35); out[7][7]=15.
   - out_valid=1 one cycle after beat 15; in_ready=0.
2. From the state left by test 1, hold out_ready=0 for 10 cycles, then pulse it.
   - out stays stable throughout.
   - out_valid falls after the handshake; in_ready=1 the next cycle.
3. in_last on beat 5: frame_err pulses once, no out_valid. A following correct 16-beat frame publishes correctly.
4. Beat 15 sent without in_last: frame published, frame_err pulses once.
5. rst asserted after beat 9: all outputs go to their reset values. A fresh frame then lands starting at out[0][0].
6. With STREAM_CONVERT_DOUBLE_BUFFER_EN, out_ready=1, three back-to-back frames:
   - in_ready stays 1 throughout.
   - out_valid stays high continuously from the first publish.
   - Each frame's contents match.
